// File: rtl/fp16_mult_result_stage_if.sv
// Operand/result bus between a producer of fp16 operand pairs (which also
// returns the combinational multiplier product) and fp16_mult_result_stage.
//   in_valid/in_ready   : operand pair handshake
//   op_a/op_b           : fp16 operands, wired to float1/float2 of the multiplier
//   product             : fp16 product returned by the multiplier in the same cycle
//   out_valid/out_ready : result handshake
//   out_result/out_flags: head fp16 result and its {NV,OF,UF,SUB} flags
interface fp16_mult_result_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] product;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_flags;

    modport master (
        output in_valid, op_a, op_b, product, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, op_a, op_b, product, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp16_mult_result_stage.sv
// Registered issue/result stage around the combinational fp16 multiplier.
// Accepts operand pairs, classifies each product into IEEE-style exception
// flags, and queues {product, flags} in an in-order FIFO for downstream.
//   CLK, nRST    : clock, synchronous active-low reset
//   bus (slave)  : operand/result handshakes, operands and product
//   flag_clr     : clear sticky_flags (a same-cycle push loads its own flags)
//   sticky_flags : OR of flags of all results pushed since reset/clear
//   result_count : number of results popped, wrapping
module fp16_mult_result_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     CLK,
    input  logic                     nRST,
    fp16_mult_result_stage_if.slave  bus,
    input  logic                     flag_clr,
    output logic [3:0]               sticky_flags,
    output logic [CNT_W-1:0]         result_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [15:0] result;
        logic [3:0]  flags;   // {NV,OF,UF,SUB}
    } entry_t;

    entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    logic   full_c;
    logic   empty_c;
    logic   push_c;
    logic   pop_c;
    logic   nv_c;
    logic   of_c;
    logic   uf_c;
    logic   sub_c;
    logic   a_max_c;
    logic   b_max_c;
    logic   a_nz_c;
    logic   b_nz_c;
    entry_t push_entry_c;
    logic   unused_sign_c;

    // Occupancy from registered pointers only; out_ready never reaches in_ready.
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty_c = (wr_ptr == rd_ptr);
    assign push_c  = bus.in_valid && !full_c;
    assign pop_c   = !empty_c && bus.out_ready;

    assign bus.in_ready   = !full_c;
    assign bus.out_valid  = !empty_c;
    assign bus.out_result = mem[rd_ptr[AW-1:0]].result;
    assign bus.out_flags  = mem[rd_ptr[AW-1:0]].flags;

    // Operand signs do not affect classification.
    assign unused_sign_c = bus.op_a[15] ^ bus.op_b[15];

    // Exception classification of the incoming product.
    always_comb begin
        a_max_c = (bus.op_a[14:10] == 5'h1F);
        b_max_c = (bus.op_b[14:10] == 5'h1F);
        a_nz_c  = |bus.op_a[14:0];
        b_nz_c  = |bus.op_b[14:0];
        nv_c    = (bus.product[14:10] == 5'h1F) && (bus.product[9:0] != 10'd0);
        // Infinity from finite operands is an overflow; inf*x is exact.
        of_c    = (bus.product[14:10] == 5'h1F) && (bus.product[9:0] == 10'd0)
                  && !a_max_c && !b_max_c;
        // Zero from two nonzero finite operands means the result flushed.
        uf_c    = (bus.product[14:0] == 15'd0) && a_nz_c && b_nz_c
                  && !a_max_c && !b_max_c;
        sub_c   = (bus.product[14:10] == 5'd0) && (bus.product[9:0] != 10'd0);
        push_entry_c.result = bus.product;
        push_entry_c.flags  = {nv_c, of_c, uf_c, sub_c};
    end

    // FIFO storage, pointers, sticky flags and retired counter.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            mem          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sticky_flags <= 4'd0;
            result_count <= '0;
        end else begin
            if (push_c) begin
                mem[wr_ptr[AW-1:0]] <= push_entry_c;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr       <= rd_ptr + PW'(1);
                result_count <= result_count + CNT_W'(1);
            end
            if (flag_clr) begin
                sticky_flags <= push_c ? push_entry_c.flags : 4'd0;
            end else if (push_c) begin
                sticky_flags <= sticky_flags | push_entry_c.flags;
            end
        end
    end
endmodule

// File: tb/tb_fp16_mult_result_stage.sv
module tb_fp16_mult_result_stage;
    logic       CLK;
    logic       nRST;
    logic       flag_clr;
    logic [3:0] sticky_flags;
    logic [7:0] result_count;

    int n_checks;
    int n_fail;

    fp16_mult_result_stage_if bus ();

    fp16_mult_result_stage #(.DEPTH(2), .CNT_W(8)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .bus          (bus.slave),
        .flag_clr     (flag_clr),
        .sticky_flags (sticky_flags),
        .result_count (result_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [15:0] p);
        bus.in_valid = v;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.product  = p;
    endtask

    logic [3:0] sticky_m;
    logic [7:0] count_m;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sticky_m = 4'd0;
        count_m  = 8'd0;

        // {op_a, op_b, product from the multiplier, expected {NV,OF,UF,SUB}}
        vecs[0] = '{16'h3C00, 16'h4000, 16'h4000, 4'b0000};
        vecs[1] = '{16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0100};
        vecs[2] = '{16'h7C00, 16'h0000, 16'hFFFF, 4'b1000};
        vecs[3] = '{16'h0001, 16'h0001, 16'h0000, 4'b0010};
        vecs[4] = '{16'h0400, 16'h3800, 16'h0200, 4'b0001};
        vecs[5] = '{16'h3C00, 16'h3C00, 16'h3C00, 4'b0000};
        vecs[6] = '{16'h7C00, 16'h3C00, 16'h7C00, 4'b0000};
        vecs[7] = '{16'h0000, 16'h3C00, 16'h0000, 4'b0000};
        vecs[8] = '{16'h7E00, 16'h3C00, 16'h7E00, 4'b1000};
        vecs[9] = '{16'hC000, 16'h4000, 16'hC400, 4'b0000};

        nRST          = 1'b0;
        flag_clr      = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00);
        step();
        step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_result", 32'(bus.out_result), 32'd0);
        check("rst_out_flags", 32'(bus.out_flags), 32'd0);
        check("rst_sticky", 32'(sticky_flags), 32'd0);
        check("rst_count", 32'(result_count), 32'd0);
        drive(1'b0, 16'd0, 16'd0, 16'd0);
        nRST = 1'b1;
        step();

        // Table: one pair at a time, consumed the cycle after it appears.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].p);
            check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            step();
            sticky_m = sticky_m | vecs[i].flags;
            drive(1'b0, 16'd0, 16'd0, 16'd0);
            check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("v%0d_result", i), 32'(bus.out_result), 32'(vecs[i].p));
            check($sformatf("v%0d_flags", i), 32'(bus.out_flags), 32'(vecs[i].flags));
            check($sformatf("v%0d_sticky", i), 32'(sticky_flags), 32'(sticky_m));
            step();
            count_m++;
            check($sformatf("v%0d_count", i), 32'(result_count), 32'(count_m));
            check($sformatf("v%0d_empty", i), 32'(bus.out_valid), 32'd0);
        end

        // flag_clr alone
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check("clr_alone", 32'(sticky_flags), 32'd0);

        // OF into sticky, then clear together with an NV push
        drive(1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00);
        step();
        check("pre_clr_sticky", 32'(sticky_flags), 32'b0100);
        drive(1'b1, 16'h7C00, 16'h0000, 16'hFFFF);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        drive(1'b0, 16'd0, 16'd0, 16'd0);
        check("clr_with_push", 32'(sticky_flags), 32'b1000);
        check("clr_push_result", 32'(bus.out_result), 32'hFFFF);
        step();
        count_m = count_m + 8'd2;
        check("clr_seq_count", 32'(result_count), 32'(count_m));
        check("clr_seq_empty", 32'(bus.out_valid), 32'd0);

        // Fill with out_ready low, third pair held off, then drain in order.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h3C00, 16'h4000, 16'h4000);
        step();
        check("fill1_in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 16'h4000, 16'h4000, 16'h4400);
        step();
        check("fill2_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 16'h4200, 16'h4000, 16'h4600);
        step();
        check("held_in_ready", 32'(bus.in_ready), 32'd0);
        check("held_head", 32'(bus.out_result), 32'h4000);
        bus.out_ready = 1'b1;
        step();
        count_m++;
        check("drain1_head", 32'(bus.out_result), 32'h4400);
        check("drain1_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        count_m++;
        drive(1'b0, 16'd0, 16'd0, 16'd0);
        check("drain2_head", 32'(bus.out_result), 32'h4600);
        check("drain2_valid", 32'(bus.out_valid), 32'd1);
        step();
        count_m++;
        check("drain3_empty", 32'(bus.out_valid), 32'd0);
        check("drain_count", 32'(result_count), 32'(count_m));

        // Reset while results are queued
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00);
        step();
        step();
        check("pre_rst_full", 32'(bus.in_ready), 32'd0);
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        drive(1'b0, 16'd0, 16'd0, 16'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_result", 32'(bus.out_result), 32'd0);
        check("mid_rst_sticky", 32'(sticky_flags), 32'd0);
        check("mid_rst_count", 32'(result_count), 32'd0);

        // Streaming push+pop every cycle: 257 pops wraps the counter to 1.
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h3C00, 16'h3C00, 16'h3C00);
        for (int i = 0; i < 257; i++) step();
        check("stream_occupied", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 16'd0, 16'd0, 16'd0);
        step();
        check("wrap_count", 32'(result_count), 32'd1);
        check("wrap_empty", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
